// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among byte producers
module uart_tx_arbiter #(
    parameter int          NUM_REQ             = 4,
    parameter int          ID_W                = 2,
    parameter logic [23:0] DEFAULT_BIT_TMR_MAX = 24'd433,
    parameter int          BUSY_TIMEOUT        = 15,
    parameter int          LOCK_TIMEOUT        = 65535
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]   REQ_LAST,
    output logic [NUM_REQ-1:0]   REQ_ACK,
    input  logic [23:0]          CFG_BIT_TMR_MAX,
    output logic                 TX_SEND,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_READY,
    output logic [23:0]          BIT_TMR_MAX,
    output logic                 BUSY,
    output logic [ID_W-1:0]      GRANT_ID,
    output logic                 ERR_TIMEOUT,
    input  logic                 ERR_CLR
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    localparam int LT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int BT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    // Last count value before the timer expires; compares with >= so the counters saturate.
    localparam logic [LT_W-1:0] LOCK_LAST = LT_W'(LOCK_TIMEOUT - 1);
    localparam logic [BT_W-1:0] BUSY_LAST = BT_W'(BUSY_TIMEOUT - 1);
    localparam logic [ID_W-1:0] GRANT_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]         state, state_n;
    logic               lock, lock_n;
    logic [LT_W-1:0]    lock_tmr, lock_tmr_n;
    logic [BT_W-1:0]    busy_cnt, busy_cnt_n;
    logic               send_n;
    logic [7:0]         data_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [ID_W-1:0]    grant_n;
    logic [23:0]        div_n;
    logic               err_n;
    logic               err_set;
    logic               busy_n;

    logic               cand_found;
    logic [ID_W-1:0]    cand_idx;
    logic [ID_W-1:0]    scan_id;
    logic               grant_en;
    logic [ID_W-1:0]    grant_idx;

    // Round-robin search starting after the last grant; scanning from the far end
    // lets the nearest valid requester overwrite earlier hits.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_id = ID_W'((int'(GRANT_ID) + k) % NUM_REQ);
            if (REQ_VALID[scan_id]) begin
                cand_found = 1'b1;
                cand_idx   = scan_id;
            end
        end
    end

    // While locked only the current owner may be granted.
    always_comb begin
        grant_idx = lock ? GRANT_ID : cand_idx;
        grant_en  = (state == S_IDLE) && TX_READY &&
                    (lock ? REQ_VALID[GRANT_ID] : cand_found);
    end

    // Next-state and next-output computation for the whole block.
    always_comb begin
        state_n    = state;
        lock_n     = lock;
        lock_tmr_n = lock_tmr;
        busy_cnt_n = busy_cnt;
        send_n     = TX_SEND;
        data_n     = TX_DATA;
        ack_n      = '0;
        grant_n    = GRANT_ID;
        div_n      = BIT_TMR_MAX;
        err_set    = 1'b0;

        case (state)
            S_IDLE: begin
                if (TX_READY) begin
                    if (grant_en) begin
                        send_n           = 1'b1;
                        data_n           = REQ_DATA[{grant_idx, 3'b000} +: 8];
                        ack_n[grant_idx] = 1'b1;
                        grant_n          = grant_idx;
                        lock_n           = ~REQ_LAST[grant_idx];
                        lock_tmr_n       = '0;
                        busy_cnt_n       = '0;
                        state_n          = S_WAIT_BUSY;
                    end else if (lock) begin
                        if (lock_tmr >= LOCK_LAST) begin
                            lock_n     = 1'b0;
                            lock_tmr_n = '0;
                        end else begin
                            lock_tmr_n = lock_tmr + 1'b1;
                        end
                    end else begin
                        // Divisor only moves between messages, with the UART idle.
                        div_n = CFG_BIT_TMR_MAX;
                    end
                end
            end
            S_WAIT_BUSY: begin
                if (!TX_READY) begin
                    send_n     = 1'b0;
                    busy_cnt_n = '0;
                    state_n    = S_WAIT_DONE;
                end else if (busy_cnt >= BUSY_LAST) begin
                    // UART never took the byte: drop it and release any lock.
                    err_set    = 1'b1;
                    send_n     = 1'b0;
                    lock_n     = 1'b0;
                    lock_tmr_n = '0;
                    busy_cnt_n = '0;
                    state_n    = S_IDLE;
                end else begin
                    busy_cnt_n = busy_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (TX_READY) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                send_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        err_n  = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : ERR_TIMEOUT);
        busy_n = (state_n != S_IDLE) || lock_n;
    end

    // State and registered outputs; reset drops TX_SEND without waiting for a clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            lock        <= 1'b0;
            lock_tmr    <= '0;
            busy_cnt    <= '0;
            TX_SEND     <= 1'b0;
            TX_DATA     <= 8'h00;
            REQ_ACK     <= '0;
            GRANT_ID    <= GRANT_RST;
            BIT_TMR_MAX <= DEFAULT_BIT_TMR_MAX;
            ERR_TIMEOUT <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_n;
            lock        <= lock_n;
            lock_tmr    <= lock_tmr_n;
            busy_cnt    <= busy_cnt_n;
            TX_SEND     <= send_n;
            TX_DATA     <= data_n;
            REQ_ACK     <= ack_n;
            GRANT_ID    <= grant_n;
            BIT_TMR_MAX <= div_n;
            ERR_TIMEOUT <= err_n;
            BUSY        <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [3:0]  REQ_VALID = '0;
    logic [31:0] REQ_DATA = '0;
    logic [3:0]  REQ_LAST = '0;
    logic [3:0]  REQ_ACK;
    logic [23:0] CFG_BIT_TMR_MAX = 24'd3;
    logic        TX_SEND;
    logic [7:0]  TX_DATA;
    logic        TX_READY;
    logic [23:0] BIT_TMR_MAX;
    logic        BUSY;
    logic [1:0]  GRANT_ID;
    logic        ERR_TIMEOUT;
    logic        ERR_CLR = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4), .ID_W(2), .DEFAULT_BIT_TMR_MAX(24'd433),
        .BUSY_TIMEOUT(15), .LOCK_TIMEOUT(8)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_LAST(REQ_LAST), .REQ_ACK(REQ_ACK), .CFG_BIT_TMR_MAX(CFG_BIT_TMR_MAX),
        .TX_SEND(TX_SEND), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
        .BIT_TMR_MAX(BIT_TMR_MAX), .BUSY(BUSY), .GRANT_ID(GRANT_ID),
        .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    // uart_tx model: one character lasts 10 bit times of (BIT_TMR_MAX+1) cycles.
    logic        uart_ready = 1'b1;
    bit          uart_stuck = 1'b0;
    int          uart_cnt   = 0;
    logic [23:0] div_q[$];
    assign TX_READY = uart_ready;

    always @(posedge CLK) begin
        if (uart_stuck) begin
            uart_ready <= 1'b1;
        end else if (uart_ready && TX_SEND) begin
            uart_ready <= 1'b0;
            uart_cnt   <= (int'(BIT_TMR_MAX) + 1) * 10;
            div_q.push_back(BIT_TMR_MAX);
        end else if (!uart_ready) begin
            if (uart_cnt <= 1) uart_ready <= 1'b1;
            else uart_cnt <= uart_cnt - 1;
        end
    end

    // Requesters: each presents the head of its byte queue and advances on REQ_ACK.
    logic [8:0] rq[4][$];
    logic [8:0] rq_head;
    initial forever begin
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            if (REQ_ACK[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                rq_head = rq[i][0];
                REQ_VALID[i] = 1'b1;
                REQ_LAST[i] = rq_head[8];
                REQ_DATA[8*i +: 8] = rq_head[7:0];
            end else begin
                REQ_VALID[i] = 1'b0;
                REQ_LAST[i] = 1'b0;
            end
        end
    end

    // Monitor: logs grants, TX_SEND widths and cycles since TX_READY last rose.
    int         cyc = 0, last_rise = 0, ack_wide = 0, send_len = 0;
    logic       ready_d = 1'b1;
    logic [3:0] ack_d = '0;
    int         ack_id_q[$], ack_gap_q[$], len_q[$];
    logic [7:0] ack_data_q[$];
    logic [3:0] ack_vec_q[$];
    initial forever begin
        @(negedge CLK);
        cyc++;
        if (TX_READY && !ready_d) last_rise = cyc;
        ready_d = TX_READY;
        if (|REQ_ACK) begin
            ack_vec_q.push_back(REQ_ACK);
            ack_id_q.push_back(int'(GRANT_ID));
            ack_data_q.push_back(TX_DATA);
            ack_gap_q.push_back(cyc - last_rise);
            if (REQ_ACK == ack_d) ack_wide++;
        end
        ack_d = REQ_ACK;
        if (TX_SEND) send_len++;
        else if (send_len != 0) begin
            len_q.push_back(send_len);
            send_len = 0;
        end
    end

    task automatic clear_logs();
        ack_vec_q.delete(); ack_id_q.delete(); ack_data_q.delete(); ack_gap_q.delete();
        len_q.delete(); div_q.delete(); ack_wide = 0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        for (int c = 0; c < budget && ack_id_q.size() < n; c++) @(negedge CLK);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (!BUSY && TX_READY && !TX_SEND) break;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (TX_SEND !== 1'b0) begin bad++; $display("FAIL rst_send got=%0h exp=0", TX_SEND); end
        total++; if (TX_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h exp=0", TX_DATA); end
        total++; if (REQ_ACK !== 4'h0) begin bad++; $display("FAIL rst_ack got=%0h exp=0", REQ_ACK); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", BUSY); end
        total++; if (ERR_TIMEOUT !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", ERR_TIMEOUT); end
        total++; if (GRANT_ID !== 2'd3) begin bad++; $display("FAIL rst_grant got=%0d exp=3", GRANT_ID); end
        total++; if (BIT_TMR_MAX !== 24'd433) begin bad++; $display("FAIL rst_div got=%0d exp=433", BIT_TMR_MAX); end
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (BIT_TMR_MAX !== 24'd3) begin bad++; $display("FAIL idle_div_load got=%0d exp=3", BIT_TMR_MAX); end
    endtask

    task automatic test_round_robin();
        int         exp_id[5]  = '{0, 1, 2, 3, 0};
        logic [7:0] exp_dat[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        logic [3:0] one = 4'b0001;
        clear_logs();
        rq[0].push_back({1'b1, 8'hA0}); rq[0].push_back({1'b1, 8'hA4});
        rq[1].push_back({1'b1, 8'hA1});
        rq[2].push_back({1'b1, 8'hA2});
        rq[3].push_back({1'b1, 8'hA3});
        wait_acks(5, 600);
        wait_idle(200);
        total++; if (ack_id_q.size() != 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", ack_id_q.size()); end
        total++; if (len_q.size() != 5) begin bad++; $display("FAIL rr_sends got=%0d exp=5", len_q.size()); end
        total++; if (ack_wide != 0) begin bad++; $display("FAIL rr_ack_width got=%0d exp=0", ack_wide); end
        if (ack_id_q.size() == 5 && len_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                total++; if (ack_id_q[k] != exp_id[k]) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, ack_id_q[k], exp_id[k]); end
                total++; if (ack_data_q[k] !== exp_dat[k]) begin bad++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, ack_data_q[k], exp_dat[k]); end
                total++; if (ack_vec_q[k] !== (one << exp_id[k])) begin bad++; $display("FAIL rr_ackvec[%0d] got=%0b exp=%0b", k, ack_vec_q[k], one << exp_id[k]); end
                total++; if (len_q[k] != 2) begin bad++; $display("FAIL rr_send_len[%0d] got=%0d exp=2", k, len_q[k]); end
                if (k > 0) begin
                    total++; if (ack_gap_q[k] != 2) begin bad++; $display("FAIL rr_gap[%0d] got=%0d exp=2", k, ack_gap_q[k]); end
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        int         exp_id[4]  = '{2, 2, 2, 0};
        logic [7:0] exp_dat[4] = '{8'h48, 8'h49, 8'h0A, 8'h55};
        clear_logs();
        rq[0].push_back({1'b1, 8'h55});
        rq[2].push_back({1'b0, 8'h48}); rq[2].push_back({1'b0, 8'h49}); rq[2].push_back({1'b1, 8'h0A});
        wait_acks(4, 600);
        wait_idle(200);
        total++; if (ack_id_q.size() != 4) begin bad++; $display("FAIL lock_count got=%0d exp=4", ack_id_q.size()); end
        if (ack_id_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++; if (ack_id_q[k] != exp_id[k]) begin bad++; $display("FAIL lock_id[%0d] got=%0d exp=%0d", k, ack_id_q[k], exp_id[k]); end
                total++; if (ack_data_q[k] !== exp_dat[k]) begin bad++; $display("FAIL lock_data[%0d] got=%0h exp=%0h", k, ack_data_q[k], exp_dat[k]); end
            end
            total++; if (ack_gap_q[3] != 2) begin bad++; $display("FAIL lock_release_gap got=%0d exp=2", ack_gap_q[3]); end
        end
    endtask

    task automatic test_lock_timeout();
        clear_logs();
        rq[1].push_back({1'b0, 8'h31});
        rq[3].push_back({1'b1, 8'h33});
        wait_acks(2, 600);
        wait_idle(200);
        total++; if (ack_id_q.size() != 2) begin bad++; $display("FAIL lto_count got=%0d exp=2", ack_id_q.size()); end
        if (ack_id_q.size() == 2) begin
            total++; if (ack_id_q[0] != 1) begin bad++; $display("FAIL lto_first got=%0d exp=1", ack_id_q[0]); end
            total++; if (ack_id_q[1] != 3) begin bad++; $display("FAIL lto_second got=%0d exp=3", ack_id_q[1]); end
            total++; if (ack_data_q[1] !== 8'h33) begin bad++; $display("FAIL lto_data got=%0h exp=33", ack_data_q[1]); end
            total++; if (ack_gap_q[1] != 10) begin bad++; $display("FAIL lto_gap got=%0d exp=10", ack_gap_q[1]); end
        end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL lto_busy got=%0h exp=0", BUSY); end
    endtask

    task automatic test_baud_change();
        CFG_BIT_TMR_MAX = 24'd433;
        repeat (3) @(negedge CLK);
        total++; if (BIT_TMR_MAX !== 24'd433) begin bad++; $display("FAIL baud_start got=%0d exp=433", BIT_TMR_MAX); end
        clear_logs();
        rq[0].push_back({1'b0, 8'h10}); rq[0].push_back({1'b1, 8'h11});
        wait_acks(1, 50);
        repeat (20) @(negedge CLK);
        CFG_BIT_TMR_MAX = 24'd10;
        repeat (5) @(negedge CLK);
        total++; if (BIT_TMR_MAX !== 24'd433) begin bad++; $display("FAIL baud_mid_char got=%0d exp=433", BIT_TMR_MAX); end
        wait_acks(2, 6000);
        total++; if (BIT_TMR_MAX !== 24'd433) begin bad++; $display("FAIL baud_mid_msg got=%0d exp=433", BIT_TMR_MAX); end
        wait_idle(6000);
        repeat (2) @(negedge CLK);
        total++; if (BIT_TMR_MAX !== 24'd10) begin bad++; $display("FAIL baud_after_msg got=%0d exp=10", BIT_TMR_MAX); end
        rq[0].push_back({1'b1, 8'h12});
        wait_acks(3, 100);
        wait_idle(1000);
        total++; if (div_q.size() != 3) begin bad++; $display("FAIL baud_chars got=%0d exp=3", div_q.size()); end
        if (div_q.size() == 3) begin
            total++; if (div_q[1] !== 24'd433) begin bad++; $display("FAIL baud_char1 got=%0d exp=433", div_q[1]); end
            total++; if (div_q[2] !== 24'd10) begin bad++; $display("FAIL baud_char2 got=%0d exp=10", div_q[2]); end
        end
    endtask

    task automatic test_busy_timeout();
        clear_logs();
        uart_stuck = 1'b1;
        @(negedge CLK);
        rq[1].push_back({1'b0, 8'h77});
        wait_acks(1, 50);
        wait_idle(50);
        total++; if (len_q.size() != 1) begin bad++; $display("FAIL bto_sends got=%0d exp=1", len_q.size()); end
        if (len_q.size() == 1) begin
            total++; if (len_q[0] != 15) begin bad++; $display("FAIL bto_send_len got=%0d exp=15", len_q[0]); end
        end
        total++; if (ERR_TIMEOUT !== 1'b1) begin bad++; $display("FAIL bto_err_set got=%0h exp=1", ERR_TIMEOUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL bto_lock_clear got=%0h exp=0", BUSY); end
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        total++; if (ERR_TIMEOUT !== 1'b0) begin bad++; $display("FAIL bto_err_clr got=%0h exp=0", ERR_TIMEOUT); end
        ERR_CLR = 1'b1;
        rq[1].push_back({1'b1, 8'h78});
        wait_acks(2, 50);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!TX_SEND) break;
        end
        total++; if (ERR_TIMEOUT !== 1'b1) begin bad++; $display("FAIL bto_set_wins got=%0h exp=1", ERR_TIMEOUT); end
        ERR_CLR = 1'b0;
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        uart_stuck = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_wait_done();
        int early = 0;
        clear_logs();
        rq[2].push_back({1'b1, 8'h66});
        wait_acks(1, 50);
        repeat (10) @(negedge CLK);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL rwd_pre_busy got=%0h exp=1", BUSY); end
        #2 RESET_N = 1'b0;
        #1;
        total++; if (TX_SEND !== 1'b0) begin bad++; $display("FAIL rwd_send got=%0h exp=0", TX_SEND); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rwd_busy got=%0h exp=0", BUSY); end
        total++; if (GRANT_ID !== 2'd3) begin bad++; $display("FAIL rwd_grant got=%0d exp=3", GRANT_ID); end
        total++; if (BIT_TMR_MAX !== 24'd433) begin bad++; $display("FAIL rwd_div got=%0d exp=433", BIT_TMR_MAX); end
        total++; if (TX_DATA !== 8'h00) begin bad++; $display("FAIL rwd_data got=%0h exp=0", TX_DATA); end
        @(negedge CLK);
        RESET_N = 1'b1;
        clear_logs();
        rq[0].push_back({1'b1, 8'h70});
        rq[2].push_back({1'b1, 8'h72});
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (TX_READY) break;
            if (|REQ_ACK) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL rwd_early_grant got=%0d exp=0", early); end
        total++; if (TX_READY !== 1'b1) begin bad++; $display("FAIL rwd_ready_wait got=%0h exp=1", TX_READY); end
        wait_acks(2, 10000);
        wait_idle(6000);
        total++; if (ack_id_q.size() != 2) begin bad++; $display("FAIL rwd_count got=%0d exp=2", ack_id_q.size()); end
        if (ack_id_q.size() == 2) begin
            total++; if (ack_id_q[0] != 0) begin bad++; $display("FAIL rwd_first got=%0d exp=0", ack_id_q[0]); end
            total++; if (ack_data_q[0] !== 8'h70) begin bad++; $display("FAIL rwd_first_data got=%0h exp=70", ack_data_q[0]); end
            total++; if (ack_id_q[1] != 2) begin bad++; $display("FAIL rwd_second got=%0d exp=2", ack_id_q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_lock_timeout();
        test_baud_change();
        test_busy_timeout();
        test_reset_wait_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance among NUM_REQ byte producers, for example the debug monitor, the modem AT bridge and the boot logger. It arbitrates round-robin, with optional packet locking so that multi-byte messages are never interleaved. It drives the SEND/DATA/READY handshake of uart_tx and owns its BIT_TMR_MAX (baud) setting, which changes only between characters.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of GRANT_ID; must satisfy 2**ID_W >= NUM_REQ
DEFAULT_BIT_TMR_MAX, 24'd433, baud divisor loaded at reset
BUSY_TIMEOUT, 15, cycles allowed for TX_READY to fall after SEND
LOCK_TIMEOUT, 65535, idle cycles a locked owner may hold the UART

Ports:
CLK  in  1  single clock
RESET_N  in  1  asynchronous, active-low reset
REQ_VALID  in  NUM_REQ  per-requester byte available
REQ_DATA  in  8*NUM_REQ  byte for requester i, on bits [8i+7:8i]
REQ_LAST  in  NUM_REQ  byte is the last of a message; releases the lock
REQ_ACK  out  NUM_REQ  one-cycle pulse: byte accepted
CFG_BIT_TMR_MAX  in  24  requested baud divisor
TX_SEND  out  1  to uart_tx SEND
TX_DATA  out  8  to uart_tx DATA
TX_READY  in  1  from uart_tx READY
BIT_TMR_MAX  out  24  to uart_tx BIT_TMR_MAX
BUSY  out  1  state != IDLE, or a lock is held
GRANT_ID  out  ID_W  index of the last granted requester
ERR_TIMEOUT  out  1  sticky: busy timeout occurred
ERR_CLR  in  1  clears ERR_TIMEOUT

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_N.
- Reset values (all outputs registered):
  - TX_SEND=0, TX_DATA=0, REQ_ACK=0, BUSY=0, ERR_TIMEOUT=0.
  - GRANT_ID=NUM_REQ-1, so requester 0 has first priority.
  - BIT_TMR_MAX=DEFAULT_BIT_TMR_MAX.
  - State=IDLE, lock cleared, timers cleared.
- Reset mid-character: drops TX_SEND immediately. The uart_tx instance is not reset by this block; after reset the block waits in IDLE until TX_READY=1.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, with TX_READY=1 and lock clear:
  - Candidate = first i with REQ_VALID[i]=1, searching GRANT_ID+1 upward with wrap modulo NUM_REQ.
  - On a grant at cycle t: TX_DATA<=REQ_DATA[g], TX_SEND<=1, REQ_ACK[g]<=1, GRANT_ID<=g, state<=WAIT_BUSY.
  - Lock<=~REQ_LAST[g].
- IDLE, with TX_READY=1 and lock set:
  - Only the owner (GRANT_ID) is eligible; other requesters wait even if valid.
  - Each owner-idle cycle increments the lock timer. When it reaches LOCK_TIMEOUT, the lock clears and the timer resets.
  - Any owner grant resets the lock timer.
- IDLE, with no grant: BIT_TMR_MAX<=CFG_BIT_TMR_MAX, but only when the lock is clear. The divisor is never changed inside a message or a character.
- REQ_ACK handshake:
  - High exactly one cycle (t+1).
  - The requester must present its next byte or drop REQ_VALID by t+2.
  - REQ_DATA is sampled only at the grant edge.
- WAIT_BUSY:
  - TX_SEND stays 1 until TX_READY=0 is sampled; then TX_SEND<=0 and state<=WAIT_DONE.
  - Expected: TX_READY falls at t+2, so TX_SEND is high for cycles t+1 and t+2.
  - A busy counter counts cycles in WAIT_BUSY. If it reaches BUSY_TIMEOUT: ERR_TIMEOUT<=1, TX_SEND<=0, lock cleared, state<=IDLE. The byte is lost and not retried.
- WAIT_DONE: wait for TX_READY=1, then state<=IDLE. The next grant can occur the cycle after the return to IDLE, giving a minimum 1-cycle gap between characters.
- ERR_TIMEOUT:
  - Cleared by ERR_CLR in any state.
  - If ERR_CLR and a new timeout occur in the same cycle, the set wins.
- Simultaneous events:
  - REQ_VALID changing in WAIT_* states is ignored.
  - A request from the owner that arrives while its lock times out on the same edge is granted, and the lock timer resets.
- Width rules: counters saturate and never wrap. GRANT_ID arithmetic is modulo NUM_REQ, not 2**ID_W.

Test Plan:
1. After reset, REQ_VALID=4'b1111 with single-byte requests (REQ_LAST=1) and a uart_tx model at BIT_TMR_MAX=3 → grant order 0,1,2,3,0. REQ_ACK is exactly one pulse per byte, each TX_SEND is 2 cycles wide, and TX_DATA matches the granted requester's byte.
2. Requester 2 sends 0x48,0x49,0x0A with REQ_LAST only on 0x0A while requester 0 stays valid → the three bytes go out contiguously; requester 0 is granted only after 0x0A completes.
3. Locked owner 1 drops REQ_VALID after its first byte, with LOCK_TIMEOUT=8 → after 8 idle cycles the lock releases and requester 3's pending byte is sent.
4. CFG_BIT_TMR_MAX changed from 433 to 10 in mid-character and mid-message → BIT_TMR_MAX stays 433 until IDLE with the lock clear, then becomes 10. Measured bit period changes only on the next message.
5. TX_READY held at 1 (stuck UART) → TX_SEND drops after 15 cycles and ERR_TIMEOUT=1, then returns to IDLE. ERR_CLR pulse → ERR_TIMEOUT=0.
6. RESET_N asserted during WAIT_DONE → all outputs reach their reset values asynchronously. After release, no grant is made until TX_READY=1, and the first grant goes to requester 0.
